decode_regfile: RTL and testbench

- Parametrised successor of the single-cycle Y86-64 decode stage.
- Merges register-file storage, source/destination selection and a registered decode output with stall handshake.
- Adds two write-back ports: valE (execute) and valM (memory).
- Adds write-through bypass, synchronous reset and bad-icode flagging.
- Sits between fetch and execute. Fetch supplies icode/rA/rB/cnd; write-back drives the write ports.

---
 rtl/decode_regfile.sv | 117 +++++++++++
 tb/tb_decode_regfile.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register file with two write-back ports and write-through bypass,
// source/destination selection, and a stallable registered decode output.
module decode_regfile #(
    parameter int DATA_W  = 64,
    parameter int NREGS   = 15,
    parameter int RSP_IDX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic              w_e_en,
    input  logic [3:0]        w_dstE,
    input  logic [DATA_W-1:0] w_valE,
    input  logic              w_m_en,
    input  logic [3:0]        w_dstM,
    input  logic [DATA_W-1:0] w_valM,
    output logic              out_valid,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic              bad_icode
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'(RSP_IDX);
    localparam logic [3:0] NREGS_L = 4'(NREGS);

    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        sel_srcA, sel_srcB, sel_dstE, sel_dstM;
    logic              sel_bad;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Unimplemented indices (including RNONE) read as zero; bypass gives valM priority over valE.
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 4'(i)) v = regs[i];
        end
        if (idx < NREGS_L) begin
            if (w_e_en && w_dstE == idx) v = w_valE;
            if (w_m_en && w_dstM == idx) v = w_valM;
        end
        return v;
    endfunction

    always_comb begin
        sel_srcA = RNONE;
        sel_srcB = RNONE;
        sel_dstE = RNONE;
        sel_dstM = RNONE;
        sel_bad  = (icode >= 4'hC);
        case (icode)
            4'h2: begin sel_srcA = rA;  sel_dstE = cnd ? rB : RNONE; end
            4'h3: begin sel_dstE = rB; end
            4'h4: begin sel_srcA = rA;  sel_srcB = rB; end
            4'h5: begin sel_srcB = rB;  sel_dstM = rA; end
            4'h6: begin sel_srcA = rA;  sel_srcB = rB;  sel_dstE = rB; end
            4'h8: begin sel_srcB = RSP; sel_dstE = RSP; end
            4'h9: begin sel_srcA = RSP; sel_srcB = RSP; sel_dstE = RSP; end
            4'hA: begin sel_srcA = rA;  sel_srcB = RSP; sel_dstE = RSP; end
            4'hB: begin sel_srcA = RSP; sel_srcB = RSP; sel_dstE = RSP; sel_dstM = rA; end
            default: ;
        endcase
        // Bad icodes fall to default, so their sources are RNONE and operands read as zero.
        rd_a = read_port(sel_srcA);
        rd_b = read_port(sel_srcB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            out_valid <= 1'b0;
            valA      <= '0;
            valB      <= '0;
            srcA      <= RNONE;
            srcB      <= RNONE;
            dstE      <= RNONE;
            dstM      <= RNONE;
            bad_icode <= 1'b0;
        end else begin
            // The later valM assignment overrides valE when both hit the same index.
            for (int i = 0; i < NREGS; i++) begin
                if (w_e_en && w_dstE == 4'(i)) regs[i] <= w_valE;
                if (w_m_en && w_dstM == 4'(i)) regs[i] <= w_valM;
            end
            if (!stall) begin
                if (in_valid) begin
                    out_valid <= 1'b1;
                    valA      <= rd_a;
                    valB      <= rd_b;
                    srcA      <= sel_srcA;
                    srcB      <= sel_srcB;
                    dstE      <= sel_dstE;
                    dstM      <= sel_dstM;
                    bad_icode <= sel_bad;
                end else begin
                    out_valid <= 1'b0;
                    srcA      <= RNONE;
                    srcB      <= RNONE;
                    dstE      <= RNONE;
                    dstM      <= RNONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: directed plan sequences, a decode-selection table and
// randomized traffic checked against a spec-level reference model.
module tb_decode_regfile;

    localparam int DATA_W  = 64;
    localparam int NREGS   = 15;
    localparam int RSP_IDX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_valid, stall, cnd;
    logic [3:0]        icode, ra, rb;
    logic              w_e_en, w_m_en;
    logic [3:0]        w_dstE, w_dstM;
    logic [DATA_W-1:0] w_valE, w_valM;

    logic              out_valid, bad_icode;
    logic [DATA_W-1:0] valA, valB;
    logic [3:0]        srcA, srcB, dstE, dstM;

    logic              out_valid_8, bad_icode_8;
    logic [DATA_W-1:0] valA_8, valB_8;
    logic [3:0]        srcA_8, srcB_8, dstE_8, dstM_8;

    decode_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RSP_IDX(RSP_IDX)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .icode(icode), .rA(ra), .rB(rb), .cnd(cnd),
        .w_e_en(w_e_en), .w_dstE(w_dstE), .w_valE(w_valE),
        .w_m_en(w_m_en), .w_dstM(w_dstM), .w_valM(w_valM),
        .out_valid(out_valid), .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .bad_icode(bad_icode)
    );

    decode_regfile #(.DATA_W(DATA_W), .NREGS(8), .RSP_IDX(RSP_IDX)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .icode(icode), .rA(ra), .rB(rb), .cnd(cnd),
        .w_e_en(w_e_en), .w_dstE(w_dstE), .w_valE(w_valE),
        .w_m_en(w_m_en), .w_dstM(w_dstM), .w_valM(w_valM),
        .out_valid(out_valid_8), .valA(valA_8), .valB(valB_8),
        .srcA(srcA_8), .srcB(srcB_8), .dstE(dstE_8), .dstM(dstM_8), .bad_icode(bad_icode_8)
    );

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        sa;
        logic [3:0]        sb;
        logic [3:0]        de;
        logic [3:0]        dm;
        logic              bad;
    } out_t;

    typedef struct packed {
        logic [3:0] icode;
        logic       cnd;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] de;
        logic [3:0] dm;
        logic       bad;
    } vec_t;

    out_t act;
    assign act = {out_valid, valA, valB, srcA, srcB, dstE, dstM, bad_icode};

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values and expected decode outputs.
    logic [DATA_W-1:0] m_regs [16];
    out_t              m_out;

    function automatic out_t mk(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] de,
                                input logic [3:0] dm, input logic bad);
        return {v, a, b, sa, sb, de, dm, bad};
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input logic [3:0] idx);
        if (int'(idx) >= NREGS) return '0;
        if (w_m_en && w_dstM == idx) return w_valM;
        if (w_e_en && w_dstE == idx) return w_valE;
        return m_regs[idx];
    endfunction

    task automatic model_step();
        logic [3:0] sa, sb, de, dm;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_out = mk(1'b0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
            return;
        end
        if (!stall && in_valid) begin
            sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
            if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
            if (icode inside {4'h9, 4'hB})             sa = 4'(RSP_IDX);
            if (icode inside {4'h4, 4'h5, 4'h6})       sb = rb;
            if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'(RSP_IDX);
            if (icode inside {4'h3, 4'h6} || (icode == 4'h2 && cnd)) de = rb;
            if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'(RSP_IDX);
            if (icode inside {4'h5, 4'hB})             dm = ra;
            if (icode >= 4'hC)
                m_out = mk(1'b1, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
            else
                m_out = mk(1'b1, m_read(sa), m_read(sb), sa, sb, de, dm, 1'b0);
        end else if (!stall) begin
            m_out.v  = 1'b0;
            m_out.sa = 4'hF; m_out.sb = 4'hF; m_out.de = 4'hF; m_out.dm = 4'hF;
        end
        if (w_e_en && int'(w_dstE) < NREGS) m_regs[w_dstE] = w_valE;
        if (w_m_en && int'(w_dstM) < NREGS) m_regs[w_dstM] = w_valM;
    endtask

    // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0; cnd = 1'b0;
        icode = 4'h1; ra = 4'hF; rb = 4'hF;
        w_e_en = 1'b0; w_dstE = 4'h0; w_valE = '0;
        w_m_en = 1'b0; w_dstM = 4'h0; w_valM = '0;
    endtask

    task automatic dec(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b, input logic c);
        in_valid = 1'b1; icode = ic; ra = a; rb = b; cnd = c;
    endtask

    task automatic check_out(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{4'h0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[1]  = '{4'h1, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[3]  = '{4'h2, 1'b1, 4'h1, 4'hF, 4'h2, 4'hF, 1'b0};
        vecs[4]  = '{4'h3, 1'b0, 4'hF, 4'hF, 4'h2, 4'hF, 1'b0};
        vecs[5]  = '{4'h4, 1'b0, 4'h1, 4'h2, 4'hF, 4'hF, 1'b0};
        vecs[6]  = '{4'h5, 1'b0, 4'hF, 4'h2, 4'hF, 4'h1, 1'b0};
        vecs[7]  = '{4'h6, 1'b0, 4'h1, 4'h2, 4'h2, 4'hF, 1'b0};
        vecs[8]  = '{4'h7, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[9]  = '{4'h8, 1'b0, 4'hF, 4'h4, 4'h4, 4'hF, 1'b0};
        vecs[10] = '{4'h9, 1'b0, 4'h4, 4'h4, 4'h4, 4'hF, 1'b0};
        vecs[11] = '{4'hA, 1'b0, 4'h1, 4'h4, 4'h4, 4'hF, 1'b0};
        vecs[12] = '{4'hB, 1'b0, 4'h4, 4'h4, 4'h4, 4'h1, 1'b0};
        vecs[13] = '{4'hC, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[14] = '{4'hD, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[15] = '{4'hE, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[16] = '{4'hF, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};

        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_out = mk(1'b0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
        idle();
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        check_out("reset_state", mk(1'b0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0));

        // Basic write-then-read of two ports.
        w_e_en = 1'b1; w_dstE = 4'h0; w_valE = 64'h14;
        w_m_en = 1'b1; w_dstM = 4'h1; w_valM = 64'h15;
        cycle();
        idle(); dec(4'h6, 4'h0, 4'h1, 1'b0);
        cycle();
        check_out("opq_read", mk(1'b1, 64'h14, 64'h15, 4'h0, 4'h1, 4'h1, 4'hF, 1'b0));

        // Same-cycle dual write to %rsp: valM wins, and bypass sees it.
        dec(4'hB, 4'h2, 4'hF, 1'b0);
        w_e_en = 1'b1; w_dstE = 4'h4; w_valE = 64'h100;
        w_m_en = 1'b1; w_dstM = 4'h4; w_valM = 64'h200;
        cycle();
        check_out("popq_bypass", mk(1'b1, 64'h200, 64'h200, 4'h4, 4'h4, 4'h4, 4'h2, 1'b0));
        w_e_en = 1'b0; w_m_en = 1'b0;
        dec(4'h6, 4'h4, 4'h4, 1'b0);
        cycle();
        check_out("popq_stored", mk(1'b1, 64'h200, 64'h200, 4'h4, 4'h4, 4'h4, 4'hF, 1'b0));

        dec(4'h2, 4'h3, 4'h5, 1'b0);
        cycle();
        check_out("cmov_cnd0", mk(1'b1, '0, '0, 4'h3, 4'hF, 4'hF, 4'hF, 1'b0));
        cnd = 1'b1;
        cycle();
        check_out("cmov_cnd1", mk(1'b1, '0, '0, 4'h3, 4'hF, 4'h5, 4'hF, 1'b0));

        // Stall freezes outputs while a write still lands.
        dec(4'h4, 4'h1, 4'h0, 1'b0);
        cycle();
        check_out("stall_capture", mk(1'b1, 64'h15, 64'h14, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0));
        stall = 1'b1; dec(4'h6, 4'h2, 4'h3, 1'b0);
        w_e_en = 1'b1; w_dstE = 4'h7; w_valE = 64'h55;
        for (int i = 0; i < 3; i++) begin
            cycle();
            w_e_en = 1'b0;
            check_out("stall_hold", mk(1'b1, 64'h15, 64'h14, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0));
        end
        stall = 1'b0; dec(4'h6, 4'h7, 4'hF, 1'b0);
        cycle();
        check_out("post_stall_read", mk(1'b1, 64'h55, '0, 4'h7, 4'hF, 4'hF, 4'hF, 1'b0));

        dec(4'hE, 4'h1, 4'h2, 1'b1);
        cycle();
        check_out("bad_icode", mk(1'b1, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1));
        in_valid = 1'b0;
        cycle();
        check_out("bubble", mk(1'b0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1));

        // Reset clears storage and discards a same-cycle write.
        idle(); w_e_en = 1'b1; w_dstE = 4'h9; w_valE = 64'hAB;
        cycle();
        idle(); dec(4'h2, 4'h9, 4'hF, 1'b0);
        cycle();
        check_out("reg9_written", mk(1'b1, 64'hAB, '0, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0));
        reset = 1'b1; stall = 1'b1; w_m_en = 1'b1; w_dstM = 4'h9; w_valM = 64'h5A;
        cycle();
        check_out("reset_mid_stall", mk(1'b0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0));
        idle(); dec(4'h2, 4'h9, 4'hF, 1'b0);
        cycle();
        check_out("reg9_cleared", mk(1'b1, '0, '0, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0));

        // NREGS=8 instance: index 12 is unimplemented, index 7 is real.
        idle();
        w_e_en = 1'b1; w_dstE = 4'hC; w_valE = 64'h77;
        w_m_en = 1'b1; w_dstM = 4'h7; w_valM = 64'h33;
        cycle();
        idle(); dec(4'h6, 4'hC, 4'h7, 1'b0);
        cycle();
        check_val("n8_read12", valA_8, '0);
        check_val("n8_read7", valB_8, 64'h33);
        check_val("n8_srcA", {60'd0, srcA_8}, 64'hC);
        check_val("n15_read12", valA, 64'h77);
        w_e_en = 1'b1; w_dstE = 4'hC; w_valE = 64'h99;
        dec(4'h6, 4'hC, 4'hC, 1'b0);
        cycle();
        check_val("n8_bypass12", valA_8, '0);
        check_out("n15_bypass12", m_out);

        // Decode selection table (rA=1, rB=2).
        idle();
        for (int i = 0; i < 17; i++) begin
            dec(vecs[i].icode, 4'h1, 4'h2, vecs[i].cnd);
            cycle();
            checks++;
            if ({out_valid, srcA, srcB, dstE, dstM, bad_icode} !==
                {1'b1, vecs[i].sa, vecs[i].sb, vecs[i].de, vecs[i].dm, vecs[i].bad}) begin
                errors++;
                $display("FAIL table[%0d] icode=%h: got v=%b sa=%h sb=%h de=%h dm=%h bad=%b expected sa=%h sb=%h de=%h dm=%h bad=%b",
                         i, vecs[i].icode, out_valid, srcA, srcB, dstE, dstM, bad_icode,
                         vecs[i].sa, vecs[i].sb, vecs[i].de, vecs[i].dm, vecs[i].bad);
            end
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            icode    = 4'($urandom_range(0, 15));
            ra       = 4'($urandom_range(0, 15));
            rb       = 4'($urandom_range(0, 15));
            cnd      = 1'($urandom_range(0, 1));
            w_e_en   = 1'($urandom_range(0, 1));
            w_dstE   = 4'($urandom_range(0, 15));
            w_valE   = {$urandom, $urandom};
            w_m_en   = 1'($urandom_range(0, 1));
            w_dstM   = ($urandom_range(0, 3) == 0) ? w_dstE : 4'($urandom_range(0, 15));
            w_valM   = {$urandom, $urandom};
            cycle();
            check_out("random", m_out);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
